// File: rtl/countdown_seq_ctrl_if.sv
// Handshake/bus bundle between the button front end, the countdown
// sequencing controller and the down-counter / seven-segment mux.
// master: the side that drives buttons, preset and zero (lab top / bench).
// slave : the sequencing controller itself.
interface countdown_seq_ctrl_if;
    logic       btn_start;
    logic       btn_clear;
    logic [7:0] preset;
    logic       zero;
    logic       load;
    logic       decrease;
    logic [1:0] state;
    logic       done_led;
    logic       run_led;
    logic       digit_sel;

    modport master (
        output btn_start, btn_clear, preset, zero,
        input  load, decrease, state, done_led, run_led, digit_sel
    );

    modport slave (
        input  btn_start, btn_clear, preset, zero,
        output load, decrease, state, done_led, run_led, digit_sel
    );
endinterface

// File: rtl/countdown_seq_ctrl.sv
// Sequencing controller for the two-digit BCD countdown lab.
// Turns debounced start/stop and clear levels into an IDLE/RUN/PAUSE/DONE
// state machine, generates the one-cycle decrement strobe from a prescaler
// and runs the free-running digit-scan select for the seven-segment mux.
// The state is exported on bus.state for observation.
// rst_n is active HIGH and synchronous (name kept for the existing codebase).
// Optional macro AUTO_RELOAD_EN: when defined, reaching zero in RUN spends one
// cycle in IDLE (reloading the preset, done_led pulsing) and then returns to
// RUN automatically; when undefined, zero in RUN parks the block in DONE.
module countdown_seq_ctrl #(
    parameter int TICK_DIV = 100000000,
    parameter int SCAN_DIV = 65536
) (
    input logic               clk,
    input logic               rst_n,
    countdown_seq_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_t;

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

    state_t        cur_state;
    logic [TW-1:0] tick_cnt;
    logic [SW-1:0] scan_cnt;
    logic          decrease_r;
    logic          digit_sel_r;
    logic          start_hist;
    logic          clear_hist;
    logic          start_p;
    logic          clear_p;
`ifdef AUTO_RELOAD_EN
    logic          reload_cyc;
`endif

    // Rising-edge pulses of the debounced button levels.
    assign start_p = bus.btn_start & ~start_hist;
    assign clear_p = bus.btn_clear & ~clear_hist;

    // Main FSM, prescaler and registered decrement strobe. The prescaler only
    // advances on cycles where RUN continues into RUN, so pausing freezes the
    // partial period and decrease can never land in a non-RUN cycle.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            cur_state  <= IDLE;
            tick_cnt   <= '0;
            decrease_r <= 1'b0;
            start_hist <= 1'b0;
            clear_hist <= 1'b0;
`ifdef AUTO_RELOAD_EN
            reload_cyc <= 1'b0;
`endif
        end else begin
            start_hist <= bus.btn_start;
            clear_hist <= bus.btn_clear;
            decrease_r <= 1'b0;
            if (clear_p) begin
                cur_state <= IDLE;
                tick_cnt  <= '0;
`ifdef AUTO_RELOAD_EN
                reload_cyc <= 1'b0;
            end else if (reload_cyc) begin
                // One-cycle reload in IDLE is over: resume counting.
                cur_state  <= RUN;
                tick_cnt   <= '0;
                reload_cyc <= 1'b0;
`endif
            end else begin
                case (cur_state)
                    IDLE: begin
                        tick_cnt <= '0;
                        if (start_p && (bus.preset != 8'h00)) cur_state <= RUN;
                    end
                    RUN: begin
                        if (bus.zero) begin
                            tick_cnt <= '0;
`ifdef AUTO_RELOAD_EN
                            cur_state  <= IDLE;
                            reload_cyc <= 1'b1;
`else
                            cur_state <= DONE;
`endif
                        end else if (start_p) begin
                            cur_state <= PAUSE;
                        end else if (tick_cnt == TICK_LAST) begin
                            tick_cnt   <= '0;
                            decrease_r <= 1'b1;
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                    PAUSE: begin
                        if (start_p) cur_state <= RUN;
                    end
                    DONE: begin
                        tick_cnt <= '0;
                    end
                    default: begin
                        cur_state <= IDLE;
                        tick_cnt  <= '0;
                    end
                endcase
            end
        end
    end

    // Free-running digit scan, independent of the FSM.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            scan_cnt    <= '0;
            digit_sel_r <= 1'b0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt    <= '0;
            digit_sel_r <= ~digit_sel_r;
        end else begin
            scan_cnt <= scan_cnt + SW'(1);
        end
    end

    assign bus.state     = cur_state;
    assign bus.load      = (cur_state == IDLE);
    assign bus.run_led   = (cur_state == RUN);
`ifdef AUTO_RELOAD_EN
    assign bus.done_led  = (cur_state == DONE) | reload_cyc;
`else
    assign bus.done_led  = (cur_state == DONE);
`endif
    assign bus.decrease  = decrease_r;
    assign bus.digit_sel = digit_sel_r;

endmodule

// File: tb/tb_countdown_seq_ctrl.sv
// Bench for countdown_seq_ctrl with TICK_DIV=4, SCAN_DIV=4.
// A spec-level model runs alongside the DUT and is compared on every
// falling edge; directed scenarios add literal checks that pin the model.
module tb_countdown_seq_ctrl;
    localparam int TICK_DIV = 4;
    localparam int SCAN_DIV = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic chk_en = 1'b0;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    logic [7:0] exp_q[$];

    countdown_seq_ctrl_if bus_if ();

    countdown_seq_ctrl #(.TICK_DIV(TICK_DIV), .SCAN_DIV(SCAN_DIV)) dut (
        .clk  (clk),
        .rst_n(rst),
        .bus  (bus_if)
    );

    // clock / reset block
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // driver: advance one clock, inputs change 2 time units after the edge
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // behavioural model: mode 0 idle, 1 run, 2 pause, 3 done
    int   m_mode = 0;
    int   m_acc = 0;      // counted RUN cycles since the period chain started
    int   m_scan = 0;     // non-reset edges since reset
    logic m_dec = 1'b0;
    logic m_reload = 1'b0;
    logic m_sprev = 1'b0;
    logic m_cprev = 1'b0;

    always @(posedge clk) begin
        logic sp, cp;
        if (rst) begin
            m_mode = 0; m_acc = 0; m_scan = 0; m_dec = 1'b0;
            m_reload = 1'b0; m_sprev = 1'b0; m_cprev = 1'b0;
        end else begin
            sp = bus_if.btn_start && !m_sprev;
            cp = bus_if.btn_clear && !m_cprev;
            m_sprev = bus_if.btn_start;
            m_cprev = bus_if.btn_clear;
            m_scan++;
            m_dec = 1'b0;
            if (cp) begin
                m_mode = 0; m_acc = 0; m_reload = 1'b0;
            end else if (m_reload) begin
                m_mode = 1; m_acc = 0; m_reload = 1'b0;
            end else if (m_mode == 0) begin
                m_acc = 0;
                if (sp && bus_if.preset != 8'h00) m_mode = 1;
            end else if (m_mode == 1) begin
                if (bus_if.zero) begin
                    m_acc = 0;
`ifdef AUTO_RELOAD_EN
                    m_mode = 0; m_reload = 1'b1;
`else
                    m_mode = 3;
`endif
                end else if (sp) begin
                    m_mode = 2;
                end else begin
                    m_acc++;
                    if (m_acc % TICK_DIV == 0) m_dec = 1'b1;
                end
            end else if (m_mode == 2) begin
                if (sp) m_mode = 1;
            end else begin
                m_acc = 0;
            end
        end
    end

    // compare process: every output against the model on each falling edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("m_state", 32'(bus_if.state), 32'(m_mode));
            check("m_load", 32'(bus_if.load), 32'(m_mode == 0));
            check("m_run_led", 32'(bus_if.run_led), 32'(m_mode == 1));
            check("m_done_led", 32'(bus_if.done_led), 32'((m_mode == 3) || m_reload));
            check("m_decrease", 32'(bus_if.decrease), 32'(m_dec));
            check("m_digit_sel", 32'(bus_if.digit_sel), 32'((m_scan / SCAN_DIV) % 2));
        end
    end

    initial begin
        logic [7:0] e;
        bus_if.btn_start = 1'b0;
        bus_if.btn_clear = 1'b0;
        bus_if.preset    = 8'h00;
        bus_if.zero      = 1'b0;

        // 1. reset and scan
        rst = 1'b1;
        step();
        chk_en = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("rst_state", 32'(bus_if.state), 0);
        check("rst_load", 32'(bus_if.load), 1);
        check("rst_decrease", 32'(bus_if.decrease), 0);
        check("rst_digit_sel", 32'(bus_if.digit_sel), 0);
        repeat (3) step();
        check("scan_hold", 32'(bus_if.digit_sel), 0);
        step();
        check("scan_toggle1", 32'(bus_if.digit_sel), 1);
        repeat (4) step();
        check("scan_toggle2", 32'(bus_if.digit_sel), 0);

        // 2. start with held button, decrease on cycles 4, 8, 12
        bus_if.preset    = 8'h03;
        bus_if.btn_start = 1'b1;
        step();
        check("start_state", 32'(bus_if.state), 1);
        check("start_run_led", 32'(bus_if.run_led), 1);
        check("start_load", 32'(bus_if.load), 0);
        exp_q = {8'd4, 8'd8, 8'd12};
        for (int i = 1; i <= 12; i++) begin
            if (i == 10) bus_if.btn_start = 1'b0;
            step();
            check("held_state", 32'(bus_if.state), 1);
            if (bus_if.decrease) begin
                if (exp_q.size() == 0) begin
                    check("dec_extra", 32'(i), 0);
                end else begin
                    e = exp_q.pop_front();
                    check("dec_cycle", 32'(i), 32'(e));
                end
            end
        end
        check("dec_missing", 32'(exp_q.size()), 0);

`ifndef AUTO_RELOAD_EN
        bus_if.zero = 1'b1;
        step();
        check("done_state", 32'(bus_if.state), 3);
        check("done_led", 32'(bus_if.done_led), 1);
        repeat (3) begin
            step();
            check("done_no_dec", 32'(bus_if.decrease), 0);
        end
        // 5. DONE lockout
        repeat (3) begin
            bus_if.btn_start = 1'b1;
            step();
            bus_if.btn_start = 1'b0;
            step();
        end
        check("lockout_state", 32'(bus_if.state), 3);
        bus_if.btn_clear = 1'b1;
        step();
        check("lockout_clear", 32'(bus_if.state), 0);
        check("lockout_load", 32'(bus_if.load), 1);
        bus_if.btn_clear = 1'b0;
        bus_if.zero = 1'b0;
        step();
`else
        bus_if.btn_clear = 1'b1;
        step();
        check("ar_s2_clear", 32'(bus_if.state), 0);
        bus_if.btn_clear = 1'b0;
        step();
`endif

        // 3. pause and resume keeps the partial period
        bus_if.preset = 8'h05;
        bus_if.btn_start = 1'b1;
        step();
        bus_if.btn_start = 1'b0;
        check("p_run", 32'(bus_if.state), 1);
        step();
        step();
        bus_if.btn_start = 1'b1;
        step();
        check("p_pause", 32'(bus_if.state), 2);
        bus_if.btn_start = 1'b0;
        repeat (3) step();
        check("p_hold_state", 32'(bus_if.state), 2);
        check("p_hold_dec", 32'(bus_if.decrease), 0);
        bus_if.btn_start = 1'b1;
        step();
        check("p_resume", 32'(bus_if.state), 1);
        bus_if.btn_start = 1'b0;
        step();
        check("p_resume_early", 32'(bus_if.decrease), 0);
        step();
        check("p_resume_dec", 32'(bus_if.decrease), 1);

        // 4. clear beats start; zero preset stays idle; clear resets prescaler
        bus_if.btn_start = 1'b1;
        bus_if.btn_clear = 1'b1;
        step();
        check("clr_prio_state", 32'(bus_if.state), 0);
        check("clr_prio_load", 32'(bus_if.load), 1);
        check("clr_prio_dec", 32'(bus_if.decrease), 0);
        bus_if.btn_start = 1'b0;
        bus_if.btn_clear = 1'b0;
        step();
        bus_if.preset = 8'h00;
        bus_if.btn_start = 1'b1;
        step();
        check("zero_preset", 32'(bus_if.state), 0);
        bus_if.btn_start = 1'b0;
        step();
        bus_if.preset = 8'h01;
        bus_if.btn_start = 1'b1;
        step();
        bus_if.btn_start = 1'b0;
        check("restart_state", 32'(bus_if.state), 1);
        repeat (3) step();
        check("restart_no_early", 32'(bus_if.decrease), 0);
        step();
        check("restart_first_dec", 32'(bus_if.decrease), 1);
        bus_if.btn_clear = 1'b1;
        step();
        bus_if.btn_clear = 1'b0;
        step();

`ifdef AUTO_RELOAD_EN
        // 6. auto-reload repeat mode
        bus_if.preset = 8'h02;
        bus_if.btn_start = 1'b1;
        step();
        bus_if.btn_start = 1'b0;
        repeat (4) step();
        check("ar_first_dec", 32'(bus_if.decrease), 1);
        bus_if.zero = 1'b1;
        step();
        check("ar_reload_state", 32'(bus_if.state), 0);
        check("ar_reload_load", 32'(bus_if.load), 1);
        check("ar_reload_led", 32'(bus_if.done_led), 1);
        bus_if.zero = 1'b0;
        bus_if.btn_start = 1'b1;
        step();
        check("ar_back_run", 32'(bus_if.state), 1);
        check("ar_led_off", 32'(bus_if.done_led), 0);
        bus_if.btn_start = 1'b0;
        repeat (3) step();
        check("ar_no_early", 32'(bus_if.decrease), 0);
        step();
        check("ar_resume_dec", 32'(bus_if.decrease), 1);
        bus_if.zero = 1'b1;
        step();
        check("ar_reload2", 32'(bus_if.state), 0);
        bus_if.zero = 1'b0;
        bus_if.btn_clear = 1'b1;
        step();
        check("ar_clear_cancel", 32'(bus_if.state), 0);
        check("ar_clear_led", 32'(bus_if.done_led), 0);
        bus_if.btn_clear = 1'b0;
        step();
        check("ar_stay_idle", 32'(bus_if.state), 0);
`endif

        repeat (2) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/countdown_seq_ctrl.md
Name: countdown_seq_ctrl

Overview:
- Sequencing controller for the two-digit BCD countdown datapath (ones/tens down-counter with zero detect).
- Turns the start/stop and clear buttons into a start/pause/done state machine.
- Generates the one-cycle decrement strobe from a prescaler and the preset-load strobe.
- Generates the digit-scan select for the two-digit seven-segment display.
- Sits between the debounced button synchronisers and the down-counter and SSD mux in the lab top level.

Parameters:
- TICK_DIV, 100000000: clk cycles per decrement (1 Hz at 100 MHz); must be >= 2.
- SCAN_DIV, 65536: clk cycles per digit-scan toggle; must be >= 2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous, active-high reset (name kept per codebase; high = reset).
- btn_start  in  1  debounced start/stop level; rising edge detected internally.
- btn_clear  in  1  debounced clear level; rising edge detected internally.
- preset  in  8  BCD start value {tens, ones}.
- zero  in  1  down-counter reports 00.
- load  out  1  down-counter loads preset while high.
- decrease  out  1  one-cycle decrement strobe to the down-counter.
- state  out  2  00 IDLE, 01 RUN, 10 PAUSE, 11 DONE.
- done_led  out  1  high in DONE.
- run_led  out  1  high in RUN.
- digit_sel  out  1  0 = ones digit enabled, 1 = tens digit enabled.

Behaviour:
Reset and edge detection:
- rst_n high at posedge clk gives: state=IDLE, tick_cnt=0, scan_cnt=0, digit_sel=0, decrease=0, edge-detect history regs=0.
- load is a decode of state, so it is 1 during and after reset.
- Reset mid-RUN aborts immediately; no decrease is issued in the reset cycle.
- Edge detect: start_p = btn_start & ~btn_start_q (registered history). clear_p is formed the same way. Each pulse acts for exactly one cycle per press.

State machine (registered transitions, evaluated at posedge clk, priority top-down):
- Any state, clear_p -> IDLE, tick_cnt=0. Clear wins over a simultaneous start_p, zero or tick.
- IDLE, start_p with preset != 8'h00 -> RUN. With preset == 00, stay IDLE.
- RUN, zero=1 -> DONE. This check takes priority over start_p.
- RUN, start_p -> PAUSE.
- PAUSE, start_p -> RUN.
- DONE: start_p is ignored. Only clear_p or reset leaves DONE.

Prescaler:
- tick_cnt counts 0..TICK_DIV-1 only in RUN, then wraps to 0.
- Holds its value in PAUSE, so resume continues the partial period.
- Cleared in IDLE and DONE.
- decrease is registered: decrease=1 for one cycle after the edge where state==RUN, tick_cnt==TICK_DIV-1 and zero==0.
- First decrease occurs TICK_DIV cycles after entering RUN from IDLE.
- decrease is never asserted outside RUN and never while zero=1.

Outputs:
- load = (state==IDLE).
- done_led = (state==DONE).
- run_led = (state==RUN).
- All three are combinational state decodes.

Scan:
- scan_cnt free-runs 0..SCAN_DIV-1 in every state except reset.
- digit_sel toggles on the wrap.
- The scan is independent of the FSM.

Widths:
- tick_cnt and scan_cnt are sized with $clog2 of their parameter.
- preset is checked only for equality to zero; BCD validity is the down-counter's concern.

Optional Feature:
- Macro AUTO_RELOAD_EN.
- Defined: in RUN, zero=1 goes to IDLE for exactly one cycle (load=1, preset reloaded), then automatically returns to RUN (repeat mode). In that cycle done_led pulses high for one cycle. clear_p still forces IDLE and cancels the auto-return. start_p in the reload cycle is ignored.
- Undefined: RUN with zero=1 goes to DONE and the block stays there as described in Behaviour.

Test Plan (all scenarios TICK_DIV=4, SCAN_DIV=4):
1. Reset and scan: hold rst_n=1 for 3 cycles, then release -> state=00, load=1, decrease=0, digit_sel=0; digit_sel toggles every 4 cycles after release.
2. Start and count: preset=8'h03, btn_start held high for 10 cycles -> single transition to RUN (held level gives one edge only); decrease pulses on cycles 4, 8, 12 after RUN entry. Drive zero=1 after the third pulse -> DONE, done_led=1, no further decrease.
3. Pause and resume: RUN with tick_cnt=2, press start -> PAUSE, tick_cnt held at 2; press again -> RUN; next decrease 2 cycles later.
4. Zero preset and clear priority: preset=00 with start -> stays IDLE. In RUN, assert clear and start edges in the same cycle -> IDLE, tick_cnt=0, load=1.
5. DONE lockout: in DONE press start 3 times -> state stays 11; press clear -> IDLE.
6. AUTO_RELOAD_EN build: preset=02; on zero=1 in RUN -> one cycle of state=00 with load=1 and done_led=1, then state=01; decrease resumes 4 cycles later.
